l2cache_core: RTL

- Unified L2 cache sitting directly downstream of the I/D cache interconnect.
- Consumes the arbitrated l2cache_* strobe/cycle/write/address/data bus and returns l2cache_ack.
- On a miss, fills from physical memory over the pmem_* handshake; dirty victims are written back first.
- Organisation: 2-way set-associative, write-back, write-allocate, 1-bit LRU per set, 128-bit (16-byte) lines.

---
 rtl/l2cache_core_pkg.sv | 39 +++
 rtl/l2cache_core_if.sv | 41 ++++
 rtl/l2cache_way.sv | 59 +++++
 rtl/l2cache_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/l2cache_core_pkg.sv
// Shared types for the L2 cache slice.
// Line geometry, FSM states and the bytewise merge helper.
package lc3b_types;

  localparam int ADDR_W  = 16;
  localparam int LINE_W  = 128;
  localparam int IDX_W   = 3;
  localparam int OFS_W   = 4;
  localparam int TAG_W   = ADDR_W - IDX_W - OFS_W;
  localparam int SETS    = 1 << IDX_W;
  localparam int SEL_W   = LINE_W / 8;
  localparam int L2_WAYS = 2;

  typedef logic [TAG_W-1:0]  l2_tag_t;
  typedef logic [IDX_W-1:0]  l2_idx_t;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [ADDR_W-1:0] l2_addr_t;
  typedef logic [SEL_W-1:0]  l2_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FETCH
  } l2_state_t;

  function automatic lc3b_line l2_merge(
    input lc3b_line old_l,
    input lc3b_line new_l,
    input l2_sel_t  sel
  );
    lc3b_line r;
    r = old_l;
    for (int b = 0; b < SEL_W; b++)
      if (sel[b]) r[8*b +: 8] = new_l[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/l2cache_core_if.sv
// Upstream request bus and downstream memory bus of the L2.
// slave = cache side, master = requester/memory side.
interface l2cache_core_if;
  import lc3b_types::*;

  logic     l2cache_cyc;
  logic     l2cache_stb;
  logic     l2cache_we;
  l2_addr_t l2cache_adr;
  l2_sel_t  l2cache_sel;
  lc3b_line l2cache_wdata;
  lc3b_line l2cache_rdata;
  logic     l2cache_ack;

  logic     pmem_cyc;
  logic     pmem_stb;
  logic     pmem_we;
  l2_addr_t pmem_adr;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_ack;

  modport slave (
    input  l2cache_cyc, l2cache_stb, l2cache_we,
    input  l2cache_adr, l2cache_sel, l2cache_wdata,
    output l2cache_rdata, l2cache_ack,
    output pmem_cyc, pmem_stb, pmem_we,
    output pmem_adr, pmem_wdata,
    input  pmem_rdata, pmem_ack
  );

  modport master (
    output l2cache_cyc, l2cache_stb, l2cache_we,
    output l2cache_adr, l2cache_sel, l2cache_wdata,
    input  l2cache_rdata, l2cache_ack,
    input  pmem_cyc, pmem_stb, pmem_we,
    input  pmem_adr, pmem_wdata,
    output pmem_rdata, pmem_ack
  );

endinterface

// File: rtl/l2cache_way.sv
// One way of the L2: tag/valid/dirty/data arrays.
// Combinational hit compare, fill and byte-merge write ports.
module l2cache_way
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  l2_idx_t  idx,
  input  l2_tag_t  tag,
  output logic     hit,
  output logic     valid,
  output logic     dirty,
  output l2_tag_t  tag_out,
  output lc3b_line line,
  input  logic     wr_en,
  input  l2_sel_t  sel,
  input  lc3b_line wdata,
  input  logic     fill_en,
  input  lc3b_line fill_data,
  input  logic     clr_dirty
);

  l2_tag_t         tags [SETS];
  lc3b_line        data [SETS];
  logic [SETS-1:0] vld;
  logic [SETS-1:0] drt;

  assign valid   = vld[idx];
  assign dirty   = drt[idx];
  assign tag_out = tags[idx];
  assign line    = data[idx];
  assign hit     = vld[idx] && (tags[idx] == tag);

  // Data and tag storage; no reset, valid qualifies contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data[idx] <= fill_data;
      tags[idx] <= tag;
    end else if (wr_en) begin
      data[idx] <= l2_merge(data[idx], wdata, sel);
    end
  end

  // Valid and dirty state bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      drt <= '0;
    end else if (fill_en) begin
      vld[idx] <= 1'b1;
      drt[idx] <= 1'b0;
    end else if (wr_en) begin
      drt[idx] <= 1'b1;
    end else if (clr_dirty) begin
      drt[idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/l2cache_core.sv
// 2-way write-back write-allocate L2 with 1-bit LRU per set.
// Optional hit/miss counters when L2CACHE_PERF_EN is defined.
module l2cache_core
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  l2cache_core_if.slave bus
`ifdef L2CACHE_PERF_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  l2_state_t state, state_nx;

  logic      req;
  l2_idx_t   idx;
  l2_tag_t   tag;
  logic      unused_ofs;

  logic [L2_WAYS-1:0] hit, vld, drt;
  logic [L2_WAYS-1:0] wr_en, fill_en, clr_dirty;
  l2_tag_t            wtag  [L2_WAYS];
  lc3b_line           wline [L2_WAYS];

  logic [SETS-1:0] lru;
  logic            lru_we;
  logic            hit_way;
  logic            victim;
  logic            vic, vic_nx;
  logic            vic_we;

  assign req        = bus.l2cache_cyc & bus.l2cache_stb;
  assign idx        = bus.l2cache_adr[OFS_W +: IDX_W];
  assign tag        = bus.l2cache_adr[ADDR_W-1 -: TAG_W];
  assign unused_ofs = ^bus.l2cache_adr[OFS_W-1:0];
  assign hit_way    = hit[1] & ~hit[0];

  for (genvar g = 0; g < L2_WAYS; g++) begin : g_way
    l2cache_way u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .tag       (tag),
      .hit       (hit[g]),
      .valid     (vld[g]),
      .dirty     (drt[g]),
      .tag_out   (wtag[g]),
      .line      (wline[g]),
      .wr_en     (wr_en[g]),
      .sel       (bus.l2cache_sel),
      .wdata     (bus.l2cache_wdata),
      .fill_en   (fill_en[g]),
      .fill_data (bus.pmem_rdata),
      .clr_dirty (clr_dirty[g])
    );
  end

  // Victim: empty way 0, then empty way 1, else LRU way.
  always_comb begin
    victim = lru[idx];
    priority case (1'b1)
      !vld[0]: victim = 1'b0;
      !vld[1]: victim = 1'b1;
      default: victim = lru[idx];
    endcase
  end

  // FSM state, LRU and latched victim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lru   <= '0;
      vic   <= 1'b0;
    end else begin
      state <= state_nx;
      if (lru_we) lru[idx] <= ~hit_way;
      if (vic_we) vic <= vic_nx;
    end
  end

  // Next state, bus outputs and array strobes.
  always_comb begin
    state_nx          = state;
    bus.l2cache_ack   = 1'b0;
    bus.l2cache_rdata = '0;
    bus.pmem_cyc      = 1'b0;
    bus.pmem_stb      = 1'b0;
    bus.pmem_we       = 1'b0;
    bus.pmem_adr      = '0;
    bus.pmem_wdata    = '0;
    wr_en             = '0;
    fill_en           = '0;
    clr_dirty         = '0;
    lru_we            = 1'b0;
    vic_we            = 1'b0;
    vic_nx            = vic;
    unique case (state)
      IDLE: begin
        if (req) state_nx = COMPARE;
      end
      COMPARE: begin
        if (!req) begin
          state_nx = IDLE;
        end else if (|hit) begin
          bus.l2cache_ack   = 1'b1;
          bus.l2cache_rdata = wline[hit_way];
          wr_en[hit_way]    = bus.l2cache_we;
          lru_we            = 1'b1;
          state_nx          = IDLE;
        end else begin
          vic_we   = 1'b1;
          vic_nx   = victim;
          state_nx = (vld[victim] & drt[victim]) ?
                     WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        bus.pmem_cyc   = 1'b1;
        bus.pmem_stb   = 1'b1;
        bus.pmem_we    = 1'b1;
        bus.pmem_adr   = {wtag[vic], idx, {OFS_W{1'b0}}};
        bus.pmem_wdata = wline[vic];
        if (bus.pmem_ack) begin
          clr_dirty[vic] = 1'b1;
          state_nx       = req ? FETCH : IDLE;
        end
      end
      FETCH: begin
        bus.pmem_cyc = 1'b1;
        bus.pmem_stb = 1'b1;
        bus.pmem_adr = {tag, idx, {OFS_W{1'b0}}};
        if (bus.pmem_ack) begin
          fill_en[vic] = 1'b1;
          state_nx     = req ? COMPARE : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef L2CACHE_PERF_EN
  logic refetch;
  logic hit_inc, miss_inc;

  assign hit_inc  = (state == COMPARE) & req & (|hit) & ~refetch;
  assign miss_inc = (state == COMPARE) & req & ~(|hit);

  // Saturating counters; a re-compare after a fill is not a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refetch    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == FETCH && bus.pmem_ack) refetch <= 1'b1;
      else if (state == COMPARE)          refetch <= 1'b0;
      if (hit_inc && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (miss_inc && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
